// File: rtl/phase_sched_pkg.sv
// Shared encodings and small helpers for the phase scheduler.
package phase_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GUARD = 2'b10
    } state_e;

    localparam logic [1:0] LVL_IDLE  = 2'd0;
    localparam logic [1:0] LVL_NORM  = 2'd1;
    localparam logic [1:0] LVL_HIGH  = 2'd2;
    localparam logic [1:0] LVL_EMERG = 2'd3;

    localparam logic [1:0] REQ_M = 2'd0;
    localparam logic [1:0] REQ_C = 2'd1;
    localparam logic [1:0] REQ_D = 2'd2;

    // Round-robin successor M->C->D->M; an out-of-range index behaves like D.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            REQ_M:   return REQ_C;
            REQ_C:   return REQ_D;
            default: return REQ_M;
        endcase
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            REQ_C:   return 3'b010;
            REQ_D:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/rr_level_pick.sv
// Combinational picker: highest nonzero level wins, ties go round-robin after ptr_i.
module rr_level_pick
    import phase_sched_pkg::*;
(
    input  logic [1:0] lvl_m_i,
    input  logic [1:0] lvl_c_i,
    input  logic [1:0] lvl_d_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] win_idx_o,
    output logic       win_vld_o
);

    always_comb begin
        logic [1:0] cand;
        logic [1:0] cand_lvl;
        logic [1:0] best_lvl;
        win_idx_o = REQ_M;
        best_lvl  = LVL_IDLE;
        cand      = ptr_i;
        cand_lvl  = LVL_IDLE;
        // Strict '>' keeps the earliest candidate in round-robin order on a tie.
        for (int k = 0; k < 3; k++) begin
            cand = rr_next(cand);
            case (cand)
                REQ_M:   cand_lvl = lvl_m_i;
                REQ_C:   cand_lvl = lvl_c_i;
                default: cand_lvl = lvl_d_i;
            endcase
            if (cand_lvl > best_lvl) begin
                best_lvl  = cand_lvl;
                win_idx_o = cand;
            end
        end
        win_vld_o = (best_lvl != LVL_IDLE);
    end

endmodule

// File: rtl/phase_scheduler.sv
// Time-shares one resource between requesters M, C and D with min/max hold
// times and an all-off guard interval between owners.
module phase_scheduler
    import phase_sched_pkg::*;
#(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16,
    parameter int GUARD    = 2,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       MS,
    input  logic [1:0]       CS,
    input  logic [1:0]       DS,
    output logic [2:0]       grant,
    output logic             guard_active,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] T_MIN  = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GUARD - 1);

    state_e           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [1:0] lvl [3];
    logic [1:0] win_idx;
    logic       win_vld;
    logic [1:0] owner_idx;
    logic [1:0] own_lvl;
    logic       other_pending;
    logic       other_higher;
    logic       emergency;
    logic       release_c;

    assign lvl[0] = MS;
    assign lvl[1] = CS;
    assign lvl[2] = DS;

    // ptr_q holds the previous owner while guarding, so it ranks last at guard end.
    rr_level_pick u_pick (
        .lvl_m_i   (MS),
        .lvl_c_i   (CS),
        .lvl_d_i   (DS),
        .ptr_i     (ptr_q),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    always_comb begin
        case (grant_q)
            3'b010:  owner_idx = REQ_C;
            3'b100:  owner_idx = REQ_D;
            default: owner_idx = REQ_M;
        endcase
    end

    always_comb begin
        own_lvl       = lvl[owner_idx];
        other_pending = 1'b0;
        other_higher  = 1'b0;
        emergency     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) != owner_idx) begin
                if (lvl[i] != LVL_IDLE)
                    other_pending = 1'b1;
                if (lvl[i] > own_lvl)
                    other_higher = 1'b1;
                if (lvl[i] == LVL_EMERG && own_lvl != LVL_EMERG)
                    emergency = 1'b1;
            end
        end
        release_c = emergency ||
                    ((cnt_q >= T_MIN) &&
                     ((own_lvl == LVL_IDLE) || other_higher ||
                      ((cnt_q == T_MAX) && other_pending)));
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = 3'b000;
                cnt_d   = '0;
                if (win_vld) begin
                    state_d = ST_GRANT;
                    grant_d = onehot3(win_idx);
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    state_d = ST_GUARD;
                    grant_d = 3'b000;
                    cnt_d   = '0;
                    ptr_d   = owner_idx;
                end else if (cnt_q < T_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt_q >= G_LAST) begin
                    cnt_d = '0;
                    if (win_vld) begin
                        state_d = ST_GRANT;
                        grant_d = onehot3(win_idx);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= 3'b000;
            cnt_q   <= '0;
            ptr_q   <= REQ_D;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant        = grant_q;
    assign state        = state_q;
    assign guard_active = (state_q == ST_GUARD);
    assign hold_cnt     = cnt_q;

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Time-shares one controlled resource (a signal phase or datapath slot) between three requesters, M, C and D.
- Each requester presents a 2-bit request level.
- Grants exactly one requester at a time, enforces minimum and maximum hold times, and inserts a guard interval between owners.
- Sits ahead of Controller_module in the same style of design and produces the `state` and one-hot grant that downstream sequencing consumes.

Parameters:
- MIN_HOLD, 4: minimum grant cycles before a normal handover (must be ≥1).
- MAX_HOLD, 16: grant cycles after which the owner yields if anyone else is waiting (must be > MIN_HOLD).
- GUARD, 2: cycles of all-off guard between owners (must be ≥1).
- CNT_W, 5: hold/guard counter width (must hold MAX_HOLD).

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- MS, input, 2: M request level. 0 = idle, 1 = normal, 2 = high, 3 = emergency.
- CS, input, 2: C request level, same encoding.
- DS, input, 2: D request level, same encoding.
- grant, output, 3: one-hot registered grant, bit0 = M, bit1 = C, bit2 = D.
- guard_active, output, 1: high during GUARD state.
- state, output, 2: 00 IDLE, 01 GRANT, 10 GUARD. 11 is illegal and goes to IDLE next cycle.
- hold_cnt, output, CNT_W: cycles the current owner has held, minus 1. Saturates at MAX_HOLD-1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=000, guard_active=0, hold_cnt=0, last-served pointer=D (so M wins the first tie).
- Reset asserted mid-grant or mid-guard: outputs drop to reset values immediately, without waiting for a clock edge.
- Arbitration (combinational pick):
  - Winner is the requester with the highest nonzero level.
  - Ties are broken round-robin, starting at the requester after the last-served pointer, in order M→C→D→M.
  - No requests means no winner.
- IDLE:
  - If a winner exists: next edge goes to GRANT, grant=onehot(winner), hold_cnt=0.
  - Latency from request seen at a clock edge to grant registered: 1 cycle.
  - Otherwise stay in IDLE.
- GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD-1. Signals used for the release decision:
  - own = owner's level.
  - other_pending = any non-owner level nonzero.
  - other_higher = any non-owner level > own.
  - emergency = any non-owner level is 3 while own < 3.
- Release condition, where T = hold_cnt:
  - emergency (ignores MIN_HOLD), OR
  - T ≥ MIN_HOLD-1 AND (own==0 OR other_higher OR (T == MAX_HOLD-1 AND other_pending)).
- On release: next edge goes to GUARD, grant=000, guard_active=1, pointer=owner, counter reset to 0.
- No release: stay in GRANT.
  - A lone owner still requesting at MAX_HOLD keeps the grant indefinitely; hold_cnt stays saturated.
- Owner drops to 0 before MIN_HOLD with no one else waiting: the grant is still held until T = MIN_HOLD-1, then released.
- GUARD:
  - Counts GUARD cycles.
  - On the last guard cycle, arbitration runs over the current requests, with the previous owner lowest in the tie order.
  - Winner exists: go to GRANT with the new one-hot grant and hold_cnt=0.
  - No winner: go to IDLE.
  - The previous owner may be re-granted if it is the only requester.
- Invariants:
  - grant has at most one bit set.
  - grant is nonzero only in GRANT.
  - guard_active is high only in GUARD.
  - No cycle exists in which one owner hands directly to another; a guard of exactly GUARD cycles always intervenes.
- Simultaneous events: an emergency and an owner drop in the same cycle resolve as a single release, into GUARD.

Decomposition:
- phase_sched_pkg holds:
  - state encodings: ST_IDLE, ST_GRANT, ST_GUARD.
  - level constants: LVL_IDLE, LVL_NORM, LVL_HIGH, LVL_EMERG.
  - requester index constants: REQ_M, REQ_C, REQ_D.
- Sub-module rr_level_pick: combinational.
  - Inputs: three 2-bit levels and the 2-bit pointer.
  - Outputs: winner index and valid.
  - Instantiated once, shared by the IDLE and GUARD paths.

Test Plan:
1. Reset, then MS=1 at cycle 2 → grant=001 at cycle 3, state=01, hold_cnt counts 0,1,2…
2. M granted with MS=1, then CS=1 from T=0 → M holds until T=15 (MAX_HOLD-1); next edge state=10, guard_active=1 for 2 cycles; then grant=010.
3. M granted at T=1, DS=3 asserted → next edge GUARD (MIN_HOLD bypassed); after 2 guard cycles grant=100.
4. MS=CS=DS=1 simultaneously from reset → grant order M, C, D, M, each held 16 cycles with a 2-cycle guard between.
5. M granted, MS drops to 0 at T=1 with no others → release at T=3; GUARD for 2 cycles; then state=00, grant=000.
6. rst pulled low mid-GRANT with no clock edge → grant=000, state=00, hold_cnt=0 immediately; after rst goes high, the first tie of MS=CS=1 is granted to M.
